// File: rtl/p10_uart_rx_pkg.sv
// Shared UART definitions: FSM state encoding and bit-timing helpers.
package p10_uart_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_t;

  localparam int unsigned NS_PER_S = 32'd1_000_000_000;

  // Integer-ns bit period divided by integer-ns clock period.
  function automatic int unsigned cycles_per_bit(input int unsigned bit_rate,
                                                 input int unsigned clk_hz);
    return (NS_PER_S / bit_rate) / (NS_PER_S / clk_hz);
  endfunction

endpackage

// File: rtl/p10_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
//  clk, resetn : clock, async active-low reset
//  d           : asynchronous input
//  q           : synchronised output (reset to RST_VAL)
module p10_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/p10_uart_rx.sv
// UART receiver: synchronises the RX pin, qualifies the start bit, samples
// data/stop bits at mid-bit and reports each frame as valid, break or error.
//  clk, resetn   : clock, async active-low reset
//  uart_rxd      : RX pin, asynchronous, idle high
//  uart_rx_en    : allows new frames to start
//  uart_rx_valid : one-cycle pulse, uart_rx_data holds a new good frame
//  uart_rx_data  : last good received payload
//  uart_rx_break : one-cycle pulse, all-zero payload with low stop bit
//  uart_rx_err   : one-cycle pulse, framing error
//  uart_rx_busy  : receiver not idle
module p10_uart_rx
  import p10_uart_rx_pkg::*;
#(
  parameter int unsigned BIT_RATE     = 9600,
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned PAYLOAD_BITS = 8,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    uart_rxd,
  input  logic                    uart_rx_en,
  output logic                    uart_rx_valid,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data,
  output logic                    uart_rx_break,
  output logic                    uart_rx_err,
  output logic                    uart_rx_busy
);

  localparam int unsigned CYCLES_PER_BIT = cycles_per_bit(BIT_RATE, CLK_HZ);
  localparam int unsigned HALF_BIT       = CYCLES_PER_BIT / 2;
  localparam int unsigned CNT_W          = 1 + $clog2(CYCLES_PER_BIT);
  localparam int unsigned IDX_W          = $clog2(PAYLOAD_BITS + STOP_BITS + 1);

  // Counter restarts at 0 on entry/sample, so the terminal value is N-1
  // to give exactly N clocks between samples.
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(PAYLOAD_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_N    = IDX_W'(STOP_BITS);

  logic rxd_s;
  logic rxd_q;

  rx_state_t               state_q,    state_d;
  logic [CNT_W-1:0]        cnt_q,      cnt_d;
  logic [IDX_W-1:0]        idx_q,      idx_d;
  logic [PAYLOAD_BITS-1:0] shreg_q,    shreg_d;
  logic [PAYLOAD_BITS-1:0] data_q,     data_d;
  logic                    stop_bad_q, stop_bad_d;
  logic                    line_ok_q,  line_ok_d;
  logic                    valid_q,    valid_d;
  logic                    brk_q,      brk_d;
  logic                    err_q,      err_d;
  logic                    busy_q;

  p10_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (uart_rxd),
    .q      (rxd_s)
  );

  // Delayed copy of the synchronised line for falling-edge detection.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rxd_q <= 1'b1;
    else         rxd_q <= rxd_s;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shreg_q    <= '0;
      data_q     <= '0;
      stop_bad_q <= 1'b0;
      line_ok_q  <= 1'b0;
      valid_q    <= 1'b0;
      brk_q      <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shreg_q    <= shreg_d;
      data_q     <= data_d;
      stop_bad_q <= stop_bad_d;
      line_ok_q  <= line_ok_d;
      valid_q    <= valid_d;
      brk_q      <= brk_d;
      err_q      <= err_d;
      busy_q     <= (state_d != ST_IDLE);
    end
  end

  // Next-state and frame decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_W'(1);
    idx_d      = idx_q;
    shreg_d    = shreg_q;
    data_d     = data_q;
    stop_bad_d = stop_bad_q;
    line_ok_d  = line_ok_q;
    valid_d    = 1'b0;
    brk_d      = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d      = '0;
        idx_d      = '0;
        stop_bad_d = 1'b0;
        // Re-arm only after the line has been seen high.
        if (rxd_s) line_ok_d = 1'b1;
        if (rxd_q && !rxd_s && uart_rx_en && line_ok_q) state_d = ST_START;
      end
      ST_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = rxd_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shreg_d = PAYLOAD_BITS'({rxd_s, shreg_q} >> 1);
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == DATA_LAST) begin
            idx_d   = '0;
            state_d = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (idx_q == STOP_N) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          if (!stop_bad_q) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
          end else begin
            line_ok_d = 1'b0;
            if (shreg_q == '0) brk_d = 1'b1;
            else               err_d = 1'b1;
          end
        end else if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          idx_d = idx_q + IDX_W'(1);
          if (!rxd_s) stop_bad_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign uart_rx_valid = valid_q;
  assign uart_rx_data  = data_q;
  assign uart_rx_break = brk_q;
  assign uart_rx_err   = err_q;
  assign uart_rx_busy  = busy_q;

endmodule

// File: tb/tb_p10_uart_rx.sv
// Bench for p10_uart_rx: a TX model drives the line and predicts the outcome
// of each frame; a per-cycle checker matches DUT pulses and data against it.
module tb_p10_uart_rx;

  localparam int CPB  = 10;
  localparam int HALF = CPB / 2;
  localparam int P    = 8;
  localparam int S    = 1;
  // 2 sync clocks, half a bit, the data+stop bits, about 2 clocks of decode.
  localparam int LAT  = 2 + HALF + (P + S) * CPB + 2;
  localparam int TOL  = 4;

  localparam int K_VALID = 0;
  localparam int K_ERR   = 1;
  localparam int K_BRK   = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         early;
    int         late;
  } ev_t;

  logic       clk        = 1'b0;
  logic       resetn     = 1'b1;
  logic       uart_rxd   = 1'b1;
  logic       uart_rx_en = 1'b1;
  logic       uart_rx_valid;
  logic [7:0] uart_rx_data;
  logic       uart_rx_break;
  logic       uart_rx_err;
  logic       uart_rx_busy;

  ev_t        exp_q[$];
  logic [7:0] exp_data = 8'h00;
  int         cyc      = 0;
  int         n_vec    = 0;
  int         n_err    = 0;
  int         n_valid  = 0;

  p10_uart_rx #(
    .BIT_RATE     (100_000),
    .CLK_HZ       (1_000_000),
    .PAYLOAD_BITS (P),
    .STOP_BITS    (S)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .uart_rxd      (uart_rxd),
    .uart_rx_en    (uart_rx_en),
    .uart_rx_valid (uart_rx_valid),
    .uart_rx_data  (uart_rx_data),
    .uart_rx_break (uart_rx_break),
    .uart_rx_err   (uart_rx_err),
    .uart_rx_busy  (uart_rx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Outcome of a frame from its payload and stop level.
  task automatic expect_frame(input logic [7:0] b, input logic stop_lvl, input int t0);
    ev_t e;
    e.kind  = stop_lvl ? K_VALID : ((b == 8'h00) ? K_BRK : K_ERR);
    e.data  = b;
    e.early = t0 + LAT - TOL;
    e.late  = t0 + LAT + TOL;
    exp_q.push_back(e);
  endtask

  // Drives one frame starting now; caller is aligned 1 time unit after posedge.
  task automatic tx_frame(input logic [7:0] b, input logic stop_lvl, input bit accept);
    int t0;
    t0       = cyc;
    uart_rxd = 1'b0;
    if (accept) expect_frame(b, stop_lvl, t0);
    hold(CPB);
    for (int i = 0; i < P; i++) begin
      uart_rxd = b[i];
      hold(CPB);
    end
    uart_rxd = stop_lvl;
    hold(CPB * S);
    uart_rxd = 1'b1;
  endtask

  // Per-cycle checker against the expected-event queue.
  always @(negedge clk) begin
    int  k;
    int  npulse;
    ev_t e;
    if (!resetn) begin
      exp_q.delete();
      exp_data = 8'h00;
      n_vec++;
      if ({uart_rx_valid, uart_rx_err, uart_rx_break, uart_rx_busy} !== 4'b0 ||
          uart_rx_data !== 8'h00) begin
        n_err++;
        $display("FAIL reset_outputs: got v=%b e=%b b=%b busy=%b d=%0h expected all 0",
                 uart_rx_valid, uart_rx_err, uart_rx_break, uart_rx_busy, uart_rx_data);
      end
    end else begin
      npulse = int'(uart_rx_valid) + int'(uart_rx_err) + int'(uart_rx_break);
      k = uart_rx_valid ? K_VALID : (uart_rx_err ? K_ERR : K_BRK);
      if (npulse > 1) begin
        n_vec++;
        n_err++;
        $display("FAIL multi_pulse: got %0d pulses at cycle %0d expected 1", npulse, cyc);
      end else if (npulse == 1) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_pulse: got kind %0d at cycle %0d expected none", k, cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.kind != k) begin
            n_err++;
            $display("FAIL pulse_kind: got %0d expected %0d (cycle %0d)", k, e.kind, cyc);
          end else if (cyc < e.early || cyc > e.late) begin
            n_err++;
            $display("FAIL pulse_time: got cycle %0d expected %0d..%0d", cyc, e.early, e.late);
          end
          if (e.kind == K_VALID) exp_data = e.data;
          if (k == K_VALID) n_valid++;
        end
      end else if (exp_q.size() > 0 && cyc > exp_q[0].late) begin
        e = exp_q.pop_front();
        n_vec++;
        n_err++;
        $display("FAIL missing_pulse: got none by cycle %0d expected kind %0d data %0h",
                 cyc, e.kind, e.data);
      end
      n_vec++;
      if (uart_rx_data !== exp_data) begin
        n_err++;
        $display("FAIL rx_data: got %0h expected %0h at cycle %0d", uart_rx_data, exp_data, cyc);
      end
    end
  end

  initial begin
    logic [7:0] b;
    int         r;
    int         v0;

    #1 resetn = 1'b0;
    hold(4);
    chk("rst_busy", 32'(uart_rx_busy), 32'd0);
    resetn = 1'b1;
    hold(5);
    chk("rst_data", 32'(uart_rx_data), 32'h00);

    // Good frame; receiver must be busy mid-frame.
    fork
      tx_frame(8'hA5, 1'b1, 1'b1);
      begin
        hold(50);
        chk("busy_mid", 32'(uart_rx_busy), 32'd1);
      end
    join
    hold(10);
    chk("t1_data", 32'(uart_rx_data), 32'hA5);
    chk("t1_nvalid", 32'(n_valid), 32'd1);
    chk("t1_idle", 32'(uart_rx_busy), 32'd0);

    // Framing error keeps previous data.
    tx_frame(8'h3C, 1'b0, 1'b1);
    hold(20);
    chk("err_data_kept", 32'(uart_rx_data), 32'hA5);

    // Short glitch is rejected, then a good frame.
    uart_rxd = 1'b0;
    hold(3);
    uart_rxd = 1'b1;
    hold(10);
    chk("glitch_idle", 32'(uart_rx_busy), 32'd0);
    tx_frame(8'h5A, 1'b1, 1'b1);
    hold(10);
    chk("t2_data", 32'(uart_rx_data), 32'h5A);

    // Line held low for 30 bit times: one break, no retrigger.
    expect_frame(8'h00, 1'b0, cyc);
    uart_rxd = 1'b0;
    hold(30 * CPB);
    chk("brk_idle_low", 32'(uart_rx_busy), 32'd0);
    uart_rxd = 1'b1;
    hold(30);
    tx_frame(8'h81, 1'b1, 1'b1);
    hold(10);
    chk("t4_data", 32'(uart_rx_data), 32'h81);

    // Back-to-back frames with no idle gap.
    v0 = n_valid;
    tx_frame(8'h00, 1'b1, 1'b1);
    tx_frame(8'hFF, 1'b1, 1'b1);
    tx_frame(8'h55, 1'b1, 1'b1);
    hold(10);
    chk("b2b_count", 32'(n_valid - v0), 32'd3);
    chk("b2b_data", 32'(uart_rx_data), 32'h55);

    // Dropping enable mid-frame completes the frame; a frame while disabled is ignored.
    fork
      tx_frame(8'h96, 1'b1, 1'b1);
      begin
        hold(30);
        uart_rx_en = 1'b0;
      end
    join
    hold(10);
    chk("en_mid_data", 32'(uart_rx_data), 32'h96);
    tx_frame(8'h69, 1'b1, 1'b0);
    hold(10);
    chk("en_off_data", 32'(uart_rx_data), 32'h96);
    uart_rx_en = 1'b1;
    hold(5);

    // Reset mid data bit 4 of 0xC3; the transmitter shares the reset and idles.
    b = 8'hC3;
    uart_rxd = 1'b0;
    hold(CPB);
    for (int i = 0; i < 4; i++) begin
      uart_rxd = b[i];
      hold(CPB);
    end
    uart_rxd = b[4];
    hold(HALF);
    resetn   = 1'b0;
    uart_rxd = 1'b1;
    hold(2);
    chk("torn_rst_data", 32'(uart_rx_data), 32'h00);
    hold(3);
    resetn = 1'b1;
    hold(30);
    tx_frame(8'h7E, 1'b1, 1'b1);
    hold(10);
    chk("t6_data", 32'(uart_rx_data), 32'h7E);

    // Randomised traffic.
    repeat (200) begin
      b = 8'($urandom);
      r = $urandom_range(0, 15);
      if (r == 0) begin
        uart_rxd = 1'b0;
        hold($urandom_range(1, 3));
        uart_rxd = 1'b1;
        hold(CPB);
      end else if (r == 1) begin
        uart_rx_en = 1'b0;
        hold(1);
        tx_frame(b, 1'b1, 1'b0);
        hold(2);
        uart_rx_en = 1'b1;
        hold(2);
      end else if (r == 2) begin
        if ($urandom_range(0, 3) == 0) b = 8'h00;
        tx_frame(b, 1'b0, 1'b1);
        hold(2 * CPB);
      end else begin
        tx_frame(b, 1'b1, 1'b1);
        if ($urandom_range(0, 1) == 1) hold($urandom_range(1, 20));
      end
    end

    hold(150);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
